vga_pixel_shifter: RTL

Final video stage after the character generator. Takes the 16-bit character line ({attribute, glyph bits}) and the pixel-aligned sync/enable/row/cursor/blink signals from the character generator. Serialises the 8 glyph bits MSB-first at one pixel per clock, resolves the attribute into 12-bit RGB through a 16-entry palette, and applies the cursor and blink rules. Drives the VGA pins with HS/VS/DE aligned to the pixels.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_palette_lut.sv | 11 +
 rtl/vga_pixel_shifter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel stage: CGA palette, attribute field
// positions and character width.
package vga_pkg;

  localparam int CHAR_W = 8;

  // Attribute byte layout: [3:0] foreground, [6:4] background, [7] blink or bg intensity
  localparam int ATTR_FG_LSB = 0;
  localparam int ATTR_FG_MSB = 3;
  localparam int ATTR_BG_LSB = 4;
  localparam int ATTR_BG_MSB = 6;
  localparam int ATTR_HI_BIT = 7;

  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/vga_palette_lut.sv
// Combinational 16-entry palette lookup: 4-bit colour index to 12-bit RGB.
module vga_palette_lut
  import vga_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [11:0] rgb_o
);

  assign rgb_o = PALETTE[idx_i];

endmodule

// File: rtl/vga_pixel_shifter.sv
// Serialises glyph bits to pixels, resolves attribute colours with cursor swap,
// and drives aligned VGA outputs. Define VGA_BLINK_EN to make attr[7] a blink bit.
module vga_pixel_shifter
  import vga_pkg::*;
#(
  parameter int CURSOR_START = 14,
  parameter int CURSOR_END   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1,
  input  logic        sec_in,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [4:0]  row_in,
  input  logic        cursor_in,
  input  logic [15:0] characterline_in,
  output logic [11:0] rgb_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out
);

  localparam logic [3:0] CUR_LO = 4'(CURSOR_START);
  localparam logic [3:0] CUR_HI = 4'(CURSOR_END);

  logic [1:0]        ph1_det_q;
  logic [CHAR_W-1:0] shift_q;
  logic [7:0]        attr_q;
  logic [2:0]        pix_cnt_q;
  logic              active_q;
  logic              de_q, hs_q, vs_q, cur_q, sec_q;
  logic [3:0]        row_q;
  logic [11:0]       rgb_q;
  logic              hs_out_q, vs_out_q, de_out_q;

  logic        load;
  logic [3:0]  fg, bg, pal_idx;
  logic        cur_on, pix;
  logic [11:0] colour;
  logic [11:0] rgb_d;
  logic        unused_row_msb;

  assign unused_row_msb = row_in[4];
  assign load = (ph1_det_q == 2'b01);

  always_comb begin
    fg = attr_q[ATTR_FG_MSB:ATTR_FG_LSB];
`ifdef VGA_BLINK_EN
    bg = {1'b0, attr_q[ATTR_BG_MSB:ATTR_BG_LSB]};
    // Blink hides the glyph before any cursor swap is considered
    if (attr_q[ATTR_HI_BIT] && !sec_q)
      fg = bg;
`else
    bg = attr_q[ATTR_HI_BIT:ATTR_BG_LSB];
`endif
    cur_on = cur_q & sec_q & (row_q >= CUR_LO) & (row_q <= CUR_HI);
    pix    = active_q & shift_q[CHAR_W-1];
    if (cur_on)
      pal_idx = pix ? bg : fg;
    else
      pal_idx = pix ? fg : bg;
  end

  vga_palette_lut u_lut (
    .idx_i (pal_idx),
    .rgb_o (colour)
  );

  assign rgb_d = de_q ? colour : 12'h000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph1_det_q <= '0;
      shift_q   <= '0;
      attr_q    <= '0;
      pix_cnt_q <= '0;
      active_q  <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      cur_q     <= 1'b0;
      sec_q     <= 1'b0;
      row_q     <= '0;
      rgb_q     <= '0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      de_out_q  <= 1'b0;
    end else begin
      ph1_det_q <= {ph1_det_q[0], ph1};
      if (load) begin
        shift_q   <= characterline_in[7:0];
        attr_q    <= characterline_in[15:8];
        pix_cnt_q <= '0;
        active_q  <= 1'b1;
        de_q      <= de_in;
        hs_q      <= hs_in;
        vs_q      <= vs_in;
        cur_q     <= cursor_in;
        sec_q     <= sec_in;
        row_q     <= row_in[3:0];
      end else if (active_q) begin
        shift_q   <= {shift_q[CHAR_W-2:0], 1'b0};
        pix_cnt_q <= pix_cnt_q + 3'd1;
        if (pix_cnt_q == 3'd7)
          active_q <= 1'b0;
      end
      rgb_q    <= rgb_d;
      hs_out_q <= hs_q;
      vs_out_q <= vs_q;
      de_out_q <= de_q;
    end
  end

  assign rgb_out = rgb_q;
  assign hs_out  = hs_out_q;
  assign vs_out  = vs_out_q;
  assign de_out  = de_out_q;

endmodule
